// File: rtl/mod_addsub_ctrl.sv
// mod_addsub_ctrl: modular add/subtract controller built around a single
// registered (N+1)-bit adder/subtractor (mpadder6).
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start, subtract     request a new operation (sampled in IDLE), op select
//   in_a, in_b, in_m    operands and modulus (a < m, b < m, m > 0)
//   result              reduced result, held until the next completion
//   done                one-cycle pulse when result updates
//   busy                high while an accepted operation is in flight

// Registered N-bit adder/subtractor; bit N is carry (add) or borrow (subtract).
module mpadder6 #(
    parameter int unsigned N = 1027
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic         subtract,
    output logic [N:0]   result
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result <= '0;
        end else if (subtract) begin
            result <= {1'b0, in_a} - {1'b0, in_b};
        end else begin
            result <= {1'b0, in_a} + {1'b0, in_b};
        end
    end

endmodule

module mod_addsub_ctrl #(
    parameter int unsigned N = 1027
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         subtract,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [N-1:0] in_m,
    output logic [N-1:0] result,
    output logic         done,
    output logic         busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        OP1  = 3'd1,
        CAP1 = 3'd2,
        OP2  = 3'd3,
        CAP2 = 3'd4
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic [N-1:0] m_q, m_d;
    logic         sub_q, sub_d;
    logic [N:0]   r1_q, r1_d;
    logic [N-1:0] result_q, result_d;
    logic         done_q, done_d;
    logic         busy_q, busy_d;

    logic [N-1:0] add_a;
    logic [N-1:0] add_b;
    logic         add_sub;
    logic [N:0]   add_res;

    mpadder6 #(.N(N)) u_adder (
        .clk      (clk),
        .reset    (reset),
        .in_a     (add_a),
        .in_b     (add_b),
        .subtract (add_sub),
        .result   (add_res)
    );

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            sub_q    <= 1'b0;
            r1_q     <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            sub_q    <= sub_d;
            r1_q     <= r1_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state, adder operand muxing and reduction select
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        sub_d    = sub_q;
        r1_d     = r1_q;
        result_d = result_q;
        done_d   = 1'b0;
        add_a    = a_q;
        add_b    = b_q;
        add_sub  = sub_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    m_d     = in_m;
                    sub_d   = subtract;
                    state_d = OP1;
                end
            end
            OP1: begin
                state_d = CAP1;
            end
            CAP1: begin
                r1_d    = add_res;
                state_d = OP2;
            end
            OP2: begin
                // Correction pass: subtract m after an add, add m back after a subtract
                add_a   = r1_q[N-1:0];
                add_b   = m_q;
                add_sub = ~sub_q;
                state_d = CAP2;
            end
            CAP2: begin
                // add_res holds r2 here; carry out of the sum means it already exceeds m
                if (sub_q) begin
                    result_d = r1_q[N] ? add_res[N-1:0] : r1_q[N-1:0];
                end else begin
                    result_d = (r1_q[N] || !add_res[N]) ? add_res[N-1:0] : r1_q[N-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// Testbench for mod_addsub_ctrl: table-driven vectors plus directed sequences
// for busy-ignore, mid-operation reset and back-to-back throughput.
module tb_mod_addsub_ctrl;

    localparam int unsigned N = 1027;

    typedef struct {
        logic         sub;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] m;
        logic [N-1:0] exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         subtract;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic [N-1:0] in_m;
    logic [N-1:0] result;
    logic         done;
    logic         busy;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [N-1:0] exp_q[$];
    logic [N-1:0] mon_e;
    vec_t         vecs[$];

    mod_addsub_ctrl #(.N(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .subtract (subtract),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_m     (in_m),
        .result   (result),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain modular arithmetic on (N+1)-bit values
    function automatic logic [N-1:0] model(input logic sub, input logic [N-1:0] a,
                                           input logic [N-1:0] b, input logic [N-1:0] m);
        logic [N:0] s;
        if (!sub) begin
            s = {1'b0, a} + {1'b0, b};
            if (s >= {1'b0, m}) s = s - {1'b0, m};
        end else if (a >= b) begin
            s = {1'b0, a} - {1'b0, b};
        end else begin
            s = {1'b0, a} + {1'b0, m} - {1'b0, b};
        end
        return s[N-1:0];
    endfunction

    function automatic logic [N-1:0] rnd_wide();
        logic [N-1:0] v = '0;
        for (int i = 0; i < (N + 31) / 32; i++) v = (v << 32) | N'($urandom);
        return v;
    endfunction

    function automatic vec_t mk(input logic sub, input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic [N-1:0] m, input logic [N-1:0] exp);
        vec_t v;
        v.sub = sub; v.a = a; v.b = b; v.m = m; v.exp = exp;
        return v;
    endfunction

    // Scoreboard: every done pops the oldest expected result
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no pending operation");
            end else begin
                mon_e = exp_q.pop_front();
                check("result", result, mon_e);
            end
        end
    end

    // Called at a negedge; returns at the negedge of the done cycle with start low
    task automatic run_op(input vec_t v, input bit disturb);
        start = 1'b1; subtract = v.sub; in_a = v.a; in_b = v.b; in_m = v.m;
        exp_q.push_back(v.exp);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("done_latency", N'(done), N'(k == 5));
            if (k <= 4) check("busy", N'(busy), N'(1));
            if (k == 1) start = 1'b0;
            if (disturb && k == 2) begin
                start = 1'b1; subtract = ~v.sub;
                in_a = rnd_wide(); in_b = rnd_wide(); in_m = rnd_wide();
            end
            if (k == 3) start = 1'b0;
        end
    endtask

    initial begin
        logic [N-1:0] ones;
        logic [N-1:0] m, a, b;
        logic         s;
        vec_t         v;

        ones = '1;
        reset = 1'b1; start = 1'b0; subtract = 1'b0;
        in_a = '0; in_b = '0; in_m = '0;

        vecs.push_back(mk(1'b0, N'(7), N'(9), N'(13), N'(3)));
        vecs.push_back(mk(1'b1, N'(3), N'(9), N'(13), N'(7)));
        vecs.push_back(mk(1'b1, N'(0), N'(0), N'(13), N'(0)));
        vecs.push_back(mk(1'b0, N'(6), N'(7), N'(13), N'(0)));
        vecs.push_back(mk(1'b0, N'(5), N'(4), N'(13), N'(9)));
        vecs.push_back(mk(1'b0, ones - 1, ones - 1, ones, ones - 2));
        vecs.push_back(mk(1'b1, N'(0), ones - 1, ones, N'(1)));
        for (int i = 0; i < 4; i++) begin
            s = 1'($urandom); a = N'($urandom_range(0, 12)); b = N'($urandom_range(0, 12));
            vecs.push_back(mk(s, a, b, N'(13), model(s, a, b, N'(13))));
        end
        for (int i = 0; i < 4; i++) begin
            m = rnd_wide() | N'(1);
            s = 1'($urandom); a = rnd_wide() % m; b = rnd_wide() % m;
            vecs.push_back(mk(s, a, b, m, model(s, a, b, m)));
        end

        #1;
        check("reset_result", result, '0);
        check("reset_done", N'(done), '0);
        check("reset_busy", N'(busy), '0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) run_op(vecs[i], 1'b0);

        // Start pulsed during busy with different operands is ignored
        run_op(mk(1'b0, N'(11), N'(10), N'(13), N'(8)), 1'b1);
        @(negedge clk);
        check("no_second_done", N'(done), '0);
        check("result_held", result, N'(8));

        // Reset during OP2 aborts with no done
        start = 1'b1; subtract = 1'b0; in_a = N'(1); in_b = N'(2); in_m = N'(13);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        #1;
        check("abort_result", result, '0);
        check("abort_busy", N'(busy), '0);
        check("abort_done", N'(done), '0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) @(negedge clk);
        check("abort_no_done_result", result, '0);
        run_op(mk(1'b0, N'(12), N'(12), N'(13), N'(11)), 1'b0);

        // start held high: three operations, done pulses 5 cycles apart
        @(negedge clk);
        v = mk(1'b0, N'(10), N'(8), N'(13), N'(5));
        start = 1'b1; subtract = v.sub; in_a = v.a; in_b = v.b; in_m = v.m;
        exp_q.push_back(v.exp);
        for (int j = 0; j < 3; j++) begin
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk);
                check("b2b_done", N'(done), N'(k == 5));
                if (k == 5) begin
                    if (j == 0) v = mk(1'b1, N'(2), N'(11), N'(13), N'(4));
                    else        v = mk(1'b0, N'(12), N'(1), N'(13), N'(0));
                    if (j < 2) begin
                        subtract = v.sub; in_a = v.a; in_b = v.b; in_m = v.m;
                        exp_q.push_back(v.exp);
                    end else begin
                        start = 1'b0;
                    end
                end
            end
        end
        @(negedge clk);
        check("b2b_no_extra_done", N'(done), '0);
        for (int k = 0; k < 6; k++) @(negedge clk);
        check("scoreboard_empty", N'(exp_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
